// File: rtl/rca_seq_ctrl.sv
// Nibble-serial add/subtract sequencer that time-multiplexes one external
// SLICE-bit ripple-carry adder, LSB slice first, with a registered inter-slice carry.
module rca_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [SLICE-1:0] rca_a,
    output logic [SLICE-1:0] rca_b,
    output logic             rca_cin,
    input  logic [SLICE-1:0] rca_sum,
    input  logic             rca_cout
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid here are decoded from state only, never from the peer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_merge;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             last;
    int               off;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (state == RUN) && (idx == LAST);
    assign off       = int'(idx) * SLICE;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rca_a      = '0;
        rca_b      = '0;
        rca_cin    = 1'b0;
        sum_merge  = sum_reg;
        sum_merge[off +: SLICE] = rca_sum;
        case (state)
            IDLE: begin
                if (accept) state_next = RUN;
            end
            RUN: begin
                rca_a   = a_reg[off +: SLICE];
                rca_b   = b_reg[off +: SLICE];
                rca_cin = carry;
                if (last) state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers load on the final slice edge so they stay put after DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            sum_q   <= '0;
            carry   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx     <= '0;
        end else begin
            if (accept) begin
                a_reg   <= a;
                b_reg   <= sub ? ~b : b;
                carry   <= sub | cin;
                idx     <= '0;
                sum_reg <= '0;
            end else if (state == RUN) begin
                sum_reg[off +: SLICE] <= rca_sum;
                carry                 <= rca_cout;
                idx                   <= last ? '0 : idx + 1'b1;
                if (last) begin
                    sum_q  <= sum_merge;
                    cout_q <= rca_cout;
                    ovf_q  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &
                              (sum_merge[WIDTH-1] != a_reg[WIDTH-1]);
                end
            end
        end
    end

endmodule
